// File: rtl/byte_mem_sequencer.sv
// byte_mem_sequencer: multi-cycle load/store sequencer between a 32-bit CPU memory stage
// and an 8-bit synchronous data memory. One byte per beat, little-endian.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   req, we, size,    access request (sampled in IDLE only), 1 = store, 1 = word,
//   sign              sign-extend byte loads
//   addr, wdata       byte address and store data, sampled with req
//   busy, done, err   non-IDLE flag, completion pulse, misaligned-word pulse (with done)
//   rdata             assembled load result, held until the next accepted load
//   mem_addr, mem_we, memory-side byte address, write strobe, store byte
//   mem_wdata
//   mem_rdata         memory read byte, valid one cycle after its address
module byte_mem_sequencer #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic              size,
    input  logic              sign,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {StIdle, StXfer, StLast, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              size_q, size_d;
    logic              sign_q, sign_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
    // A load beat issued last cycle: its byte is on mem_rdata now.
    logic              cap_q, cap_d;
    logic [1:0]        cap_idx_q, cap_idx_d;
    logic [31:0]       rdata_q, rdata_d;
    // mem_addr holds the last beat address outside XFER.
    logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;

    logic [ADDR_W-1:0] beat_addr;
    logic              in_xfer;

    assign beat_addr = base_q + ADDR_W'(cnt_q);
    assign in_xfer   = (state_q == StXfer);

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        size_d      = size_q;
        sign_d      = sign_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        cap_d       = 1'b0;
        cap_idx_d   = cap_idx_q;
        rdata_d     = rdata_q;
        addr_hold_d = addr_hold_q;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    base_d  = addr;
                    wdata_d = wdata;
                    we_d    = we;
                    size_d  = size;
                    sign_d  = sign;
                    cnt_d   = 2'd0;
                    err_d   = size && (addr[1:0] != 2'b00);
                    // Misaligned words skip the memory entirely.
                    state_d = err_d ? StDone : StXfer;
                end
            end
            StXfer: begin
                addr_hold_d = beat_addr;
                cnt_d       = cnt_q + 2'd1;
                cap_d       = !we_q;
                cap_idx_d   = cnt_q;
                if (!size_q || cnt_q == 2'd3) begin
                    state_d = we_q ? StDone : StLast;
                end
            end
            StLast: state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (cap_q) begin
            if (size_q) begin
                rdata_d[{cap_idx_q, 3'b000} +: 8] = mem_rdata;
            end else begin
                rdata_d = sign_q ? {{24{mem_rdata[7]}}, mem_rdata} : {24'b0, mem_rdata};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            base_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            size_q      <= 1'b0;
            sign_q      <= 1'b0;
            cnt_q       <= 2'd0;
            err_q       <= 1'b0;
            cap_q       <= 1'b0;
            cap_idx_q   <= 2'd0;
            rdata_q     <= '0;
            addr_hold_q <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            size_q      <= size_d;
            sign_q      <= sign_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            cap_q       <= cap_d;
            cap_idx_q   <= cap_idx_d;
            rdata_q     <= rdata_d;
            addr_hold_q <= addr_hold_d;
        end
    end

    // Outputs decode registered state only; req never reaches mem_* combinationally.
    always_comb begin
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
        err       = done && err_q;
        rdata     = rdata_q;
        mem_addr  = in_xfer ? beat_addr : addr_hold_q;
        mem_we    = in_xfer && we_q;
        mem_wdata = (in_xfer && we_q) ? wdata_q[{cnt_q, 3'b000} +: 8] : 8'h00;
    end

endmodule
